// File: rtl/imem_stream_loader_pkg.sv
// Shared definitions for the instruction-memory stream loader: FSM encoding,
// text-segment base address and frame byte-order constants.
package imem_stream_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR_HI = 3'd0,
        ST_HDR_LO = 3'd1,
        ST_WORD   = 3'd2,
        ST_CHK    = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    // im_addr 0 is the instruction the CPU fetches first after release.
    localparam logic [31:0] TEXT_BASE = 32'h0000_3000;

    // Words arrive MSB first: byte index 0 lands in [31:24], index 3 in [7:0].
    localparam int         BYTES_PER_WORD = 4;
    localparam logic [1:0] LAST_BYTE_IDX  = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/imem_stream_loader_word_packer.sv
// Assembles MSB-first bytes into 32-bit words and keeps the running XOR
// checksum of every packed byte.
module stream_word_packer
    import imem_stream_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_byte_en,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word,
    output logic [7:0]  o_csum
);

    logic [1:0]  r_byte_cnt;
    logic [23:0] r_shift;
    logic [7:0]  r_csum;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_byte_cnt <= 2'd0;
            r_shift    <= 24'd0;
            r_csum     <= 8'd0;
        end else if (i_byte_en) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_shift    <= {r_shift[15:0], i_byte};
            r_csum     <= r_csum ^ i_byte;
        end
    end

    // The word is presented combinationally in the cycle its last byte is taken.
    assign o_word_valid = i_byte_en && (r_byte_cnt == LAST_BYTE_IDX);
    assign o_word       = {r_shift, i_byte};
    assign o_csum       = r_csum;

endmodule

// File: rtl/imem_stream_loader.sv
// Receives a framed program image as a byte stream, writes it into instruction
// memory and holds the CPU in reset until a checksum-verified load completes.
module imem_stream_loader
    import imem_stream_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [15:0]       word_count,
    output logic [2:0]        o_dbg_state
);

    // Handshake: a byte moves when in_valid && in_ready on a rising edge;
    // in_valid=0 cycles are pure stalls and change nothing.

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_cnt_hi;
    logic [15:0]       r_word_count;
    logic [ADDR_W:0]   r_word_idx;
    logic              r_im_we;
    logic [ADDR_W-1:0] r_im_addr;
    logic [31:0]       r_im_wdata;

    logic              w_accept;
    logic [15:0]       w_hdr_n;
    logic [ADDR_W:0]   w_idx_next;
    logic              w_byte_en;
    logic              w_clear;
    logic              w_word_valid;
    logic [31:0]       w_word;
    logic [7:0]        w_csum;

    assign in_ready   = !rst && (r_state inside {ST_HDR_HI, ST_HDR_LO, ST_WORD, ST_CHK});
    assign w_accept   = in_valid && in_ready;
    assign w_hdr_n    = {r_cnt_hi, in_data};
    assign w_idx_next = r_word_idx + 1'b1;
    assign w_byte_en  = w_accept && (r_state == ST_WORD);
    assign w_clear    = reload && (r_state inside {ST_DONE, ST_ERR});

    stream_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_clear),
        .i_byte_en    (w_byte_en),
        .i_byte       (in_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word),
        .o_csum       (w_csum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_HDR_HI;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_HDR_HI: begin
                if (w_accept) w_next = ST_HDR_LO;
            end
            ST_HDR_LO: begin
                if (w_accept) begin
                    if (w_hdr_n == 16'd0)           w_next = ST_CHK;
                    else if (32'(w_hdr_n) > DEPTH) w_next = ST_ERR;
                    else                            w_next = ST_WORD;
                end
            end
            ST_WORD: begin
                if (w_word_valid && (32'(w_idx_next) == 32'(r_word_count)))
                    w_next = ST_CHK;
            end
            ST_CHK: begin
                if (w_accept) w_next = (in_data == w_csum) ? ST_DONE : ST_ERR;
            end
            ST_DONE, ST_ERR: begin
                if (reload) w_next = ST_HDR_HI;
            end
            default: w_next = ST_HDR_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_hi     <= 8'd0;
            r_word_count <= 16'd0;
            r_word_idx   <= '0;
            r_im_we      <= 1'b0;
            r_im_addr    <= '0;
            r_im_wdata   <= 32'd0;
        end else begin
            r_im_we <= w_word_valid;
            if (w_accept && (r_state == ST_HDR_HI)) begin
                r_cnt_hi <= in_data;
            end
            if (w_accept && (r_state == ST_HDR_LO)) begin
                r_word_count <= w_hdr_n;
                r_word_idx   <= '0;
            end
            if (w_word_valid) begin
                r_im_addr  <= r_word_idx[ADDR_W-1:0];
                r_im_wdata <= w_word;
                r_word_idx <= w_idx_next;
            end
        end
    end

    assign im_we       = r_im_we;
    assign im_addr     = r_im_addr;
    assign im_wdata    = r_im_wdata;
    assign word_count  = r_word_count;
    assign cpu_rst     = (r_state != ST_DONE);
    assign load_done   = (r_state == ST_DONE);
    assign load_err    = (r_state == ST_ERR);
    assign o_dbg_state = r_state;

endmodule
